// File: rtl/doppler_if.sv
// rtl/doppler_if.sv - sample-in / sample-out handshake bundle for doppler_emulator
interface doppler_if #(
    parameter int InputLengthBits = 12
) ();
    logic signed [InputLengthBits-1:0] in_i;
    logic signed [InputLengthBits-1:0] in_q;
    logic                              in_valid;
    logic                              in_ready;
    logic signed [InputLengthBits-1:0] out_i;
    logic signed [InputLengthBits-1:0] out_q;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output in_i, in_q, in_valid, out_ready,
        input  in_ready, out_i, out_q, out_valid
    );

    modport slave (
        input  in_i, in_q, in_valid, out_ready,
        output in_ready, out_i, out_q, out_valid
    );
endinterface

// File: rtl/doppler_emulator.sv
// rtl/doppler_emulator.sv - complex frequency shifter with ramped frequency word, 3-stage pipeline
module doppler_emulator #(
    parameter int InputLengthBits = 12,
    parameter int PhaseBits       = 24,
    parameter int LutAddrBits     = 8,
    parameter int RateInterval    = 1024,
    parameter int FreqLimit       = 2**(PhaseBits-2)
) (
    input  logic                        clk,
    input  logic                        rst,
    doppler_if.slave                    s,
    input  logic signed [PhaseBits-1:0] freq_init,
    input  logic signed [PhaseBits-1:0] freq_rate,
    input  logic                        load,
    output logic signed [PhaseBits-1:0] freq_word
);
    localparam int W        = InputLengthBits;
    localparam int PW       = 2 * W;
    localparam int LutDepth = 2**LutAddrBits;
    localparam int CntBits  = $clog2(RateInterval + 1);

    localparam logic signed [PhaseBits:0] LIM  = (PhaseBits+1)'(FreqLimit);
    localparam logic signed [PhaseBits:0] NLIM = -LIM;
    localparam logic signed [PW:0]        MAXV = (PW+1)'((2**(W-1)) - 1);
    localparam logic signed [PW:0]        MINV = -(PW+1)'(2**(W-1));

    typedef logic signed [W-1:0] samp_t;

    // Table entries are elaborated from the exact rounding rule so any width pair works.
    function automatic samp_t lut_entry(input int k, input bit want_sin);
        real ang;
        real v;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LutDepth);
        v   = real'((2**(W-1)) - 1) * (want_sin ? $sin(ang) : $cos(ang));
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return r[W-1:0];
    endfunction

    function automatic samp_t sat(input logic signed [PW:0] v);
        if (v > MAXV)      return MAXV[W-1:0];
        else if (v < MINV) return MINV[W-1:0];
        else               return v[W-1:0];
    endfunction

    samp_t cos_lut [LutDepth];
    samp_t sin_lut [LutDepth];

    for (genvar k = 0; k < LutDepth; k++) begin : g_lut
        assign cos_lut[k] = lut_entry(k, 1'b0);
        assign sin_lut[k] = lut_entry(k, 1'b1);
    end

    logic [PhaseBits-1:0]   phase;
    logic [CntBits-1:0]     ramp_cnt;
    logic                   adv;
    logic                   accept;
    logic [LutAddrBits-1:0] lut_idx;

    logic signed [PhaseBits:0]   fw_sum;
    logic signed [PhaseBits-1:0] fw_stepped;

    samp_t                s1_i, s1_q, s1_cos, s1_sin;
    logic                 s1_v;
    logic signed [PW-1:0] p_ic, p_qs, p_is, p_qc;
    logic                 s2_v;
    samp_t                out_i_r, out_q_r;
    logic                 out_valid_r;
    logic signed [PW:0]   sum_i, sum_q, sh_i, sh_q;

    // Every stage advances together; the only stall source is a held output.
    assign adv      = !(out_valid_r && !s.out_ready);
    assign accept   = s.in_valid && adv;
    assign lut_idx  = load ? '0 : phase[PhaseBits-1 -: LutAddrBits];

    assign s.in_ready  = adv;
    assign s.out_valid = out_valid_r;
    assign s.out_i     = out_i_r;
    assign s.out_q     = out_q_r;

    always_comb begin
        fw_sum     = {freq_word[PhaseBits-1], freq_word} + {freq_rate[PhaseBits-1], freq_rate};
        fw_stepped = fw_sum[PhaseBits-1:0];
        if (fw_sum > LIM)       fw_stepped = LIM[PhaseBits-1:0];
        else if (fw_sum < NLIM) fw_stepped = NLIM[PhaseBits-1:0];
    end

    always_comb begin
        sum_i = (PW+1)'(p_ic) - (PW+1)'(p_qs);
        sum_q = (PW+1)'(p_is) + (PW+1)'(p_qc);
        sh_i  = sum_i >>> (W - 1);
        sh_q  = sum_q >>> (W - 1);
    end

    // A load in the same cycle as an accept starts the new segment at phase 0 with that sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= '0;
            ramp_cnt  <= '0;
            freq_word <= '0;
        end else if (load) begin
            freq_word <= freq_init;
            ramp_cnt  <= '0;
            phase     <= accept ? freq_init : '0;
        end else if (accept) begin
            phase <= phase + freq_word;
            if (ramp_cnt == CntBits'(RateInterval - 1)) begin
                ramp_cnt  <= '0;
                freq_word <= fw_stepped;
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            out_valid_r <= 1'b0;
            out_i_r     <= '0;
            out_q_r     <= '0;
        end else if (adv) begin
            s1_v   <= s.in_valid;
            s1_i   <= s.in_i;
            s1_q   <= s.in_q;
            s1_cos <= cos_lut[lut_idx];
            s1_sin <= sin_lut[lut_idx];

            s2_v <= s1_v;
            p_ic <= PW'(s1_i) * PW'(s1_cos);
            p_qs <= PW'(s1_q) * PW'(s1_sin);
            p_is <= PW'(s1_i) * PW'(s1_sin);
            p_qc <= PW'(s1_q) * PW'(s1_cos);

            out_valid_r <= s2_v;
            if (s2_v) begin
                out_i_r <= sat(sh_i);
                out_q_r <= sat(sh_q);
            end
        end
    end
endmodule

// File: tb/tb_doppler_emulator.sv
// tb/tb_doppler_emulator.sv - randomized self-checking bench for doppler_emulator
module tb_doppler_emulator;
    localparam int W   = 12;
    localparam int PB  = 24;
    localparam int LAB = 8;
    localparam int RI0 = 16;
    localparam int LIM0 = 2**(PB-2);

    typedef struct { int i; int q; } samp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    doppler_if #(.InputLengthBits(W)) bus0 ();
    doppler_if #(.InputLengthBits(W)) bus1 ();

    logic signed [PB-1:0] freq_init0 = '0, freq_rate0 = '0, freq_word0;
    logic signed [PB-1:0] freq_init1 = '0, freq_rate1 = '0, freq_word1;
    logic                 load0 = 1'b0, load1 = 1'b0;

    doppler_emulator #(.RateInterval(RI0)) dut0 (
        .clk(clk), .rst(rst), .s(bus0),
        .freq_init(freq_init0), .freq_rate(freq_rate0), .load(load0), .freq_word(freq_word0)
    );

    doppler_emulator #(.RateInterval(4), .FreqLimit(64)) dut1 (
        .clk(clk), .rst(rst), .s(bus1),
        .freq_init(freq_init1), .freq_rate(freq_rate1), .load(load1), .freq_word(freq_word1)
    );

    int checks = 0;
    int errors = 0;

    samp_t  exp_q[$];
    samp_t  obs_q[$];
    int     m_fw, m_cnt, rate0;
    longint m_phase;
    bit     prev_stall, last_ov, last_acc;
    int     prev_i, prev_q;
    longint mask = (longint'(1) << PB) - 1;

    function automatic int lut(input int k, input bit want_sin);
        real a, v;
        a = 2.0 * 3.14159265358979323846 * k / (2**LAB);
        v = ((2**(W-1)) - 1) * (want_sin ? $sin(a) : $cos(a));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int sat(input longint v);
        if (v > (2**(W-1)) - 1) return (2**(W-1)) - 1;
        if (v < -(2**(W-1)))    return -(2**(W-1));
        return int'(v);
    endfunction

    function automatic longint clampf(input longint v, input longint lim);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic samp_t rotate(input int i, input int q, input longint ph);
        samp_t  r;
        int     k, c, s;
        longint re, im;
        k  = int'(ph >> (PB - LAB));
        c  = lut(k, 1'b0);
        s  = lut(k, 1'b1);
        re = longint'(i) * c - longint'(q) * s;
        im = longint'(i) * s + longint'(q) * c;
        r.i = sat(re >>> (W - 1));
        r.q = sat(im >>> (W - 1));
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_fw = 0; m_cnt = 0; m_phase = 0;
        prev_stall = 1'b0;
    endtask

    task automatic set_rate(input int r);
        rate0 = r;
        freq_rate0 = r[PB-1:0];
    endtask

    task automatic step(input bit iv, input int ii, input int iq, input bit ordy, input bit ld, input int finit);
        samp_t o, e;
        logic signed [PB-1:0] fw_exp;
        bit acc;
        longint ph;
        @(negedge clk);
        bus0.in_valid  = iv;
        bus0.in_i      = ii[W-1:0];
        bus0.in_q      = iq[W-1:0];
        bus0.out_ready = ordy;
        load0          = ld;
        freq_init0     = finit[PB-1:0];
        #1;
        checks++;
        if (bus0.in_ready !== !(bus0.out_valid && !ordy)) begin
            errors++;
            $display("FAIL in_ready_rule: got %b want %b", bus0.in_ready, !(bus0.out_valid && !ordy));
        end
        fw_exp = m_fw[PB-1:0];
        checks++;
        if (freq_word0 !== fw_exp) begin
            errors++;
            $display("FAIL freq_word: got %0d want %0d", freq_word0, fw_exp);
        end
        if (prev_stall) begin
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_i !== prev_i[W-1:0] || bus0.out_q !== prev_q[W-1:0]) begin
                errors++;
                $display("FAIL stall_hold: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                         bus0.out_valid, bus0.out_i, bus0.out_q, prev_i, prev_q);
            end
        end
        last_ov = bus0.out_valid;
        if (bus0.out_valid && ordy) begin
            o.i = bus0.out_i;
            o.q = bus0.out_q;
            obs_q.push_back(o);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_output: got (%0d,%0d) want none", o.i, o.q);
            end else begin
                e = exp_q.pop_front();
                if (o.i !== e.i || o.q !== e.q) begin
                    errors++;
                    $display("FAIL sample: got (%0d,%0d) want (%0d,%0d)", o.i, o.q, e.i, e.q);
                end
            end
        end
        prev_stall = bus0.out_valid && !ordy;
        prev_i = bus0.out_i;
        prev_q = bus0.out_q;

        acc = iv && bus0.in_ready;
        last_acc = acc;
        ph = ld ? 0 : m_phase;
        if (acc) exp_q.push_back(rotate(ii, iq, ph));
        if (ld) begin
            m_fw = finit;
            m_cnt = 0;
            m_phase = acc ? (longint'(finit) & mask) : 0;
        end else if (acc) begin
            m_phase = (m_phase + m_fw) & mask;
            m_cnt++;
            if (m_cnt == RI0) begin
                m_cnt = 0;
                m_fw = int'(clampf(longint'(m_fw) + rate0, LIM0));
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_obs(input string name, input int idx, input int ei, input int eq);
        checks++;
        if (idx >= obs_q.size()) begin
            errors++;
            $display("FAIL %s[%0d]: got no output want (%0d,%0d)", name, idx, ei, eq);
        end else if (obs_q[idx].i !== ei || obs_q[idx].q !== eq) begin
            errors++;
            $display("FAIL %s[%0d]: got (%0d,%0d) want (%0d,%0d)", name, idx, obs_q[idx].i, obs_q[idx].q, ei, eq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus0.in_valid = 1'b1; load0 = 1'b1; freq_init0 = 24'h123456;
        end
        @(negedge clk);
        rst = 1'b0; bus0.in_valid = 1'b0; load0 = 1'b0; bus0.out_ready = 1'b1;
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_i !== '0 || bus0.out_q !== '0 || freq_word0 !== '0
            || bus0.in_ready !== 1'b1 || freq_word1 !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b i=%0d q=%0d fw=%0d rdy=%b want 0,0,0,0,1",
                     bus0.out_valid, bus0.out_i, bus0.out_q, freq_word0, bus0.in_ready);
        end
        model_reset();
    endtask

    task automatic test_latency();
        obs_q.delete();
        set_rate(0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 1000, 0, 1, 0, 0);
        for (int d = 1; d <= 3; d++) begin
            step(0, 0, 0, 1, 0, 0);
            checks++;
            if (last_ov !== (d == 3)) begin
                errors++;
                $display("FAIL latency_c%0d: got out_valid %b want %b", d, last_ov, d == 3);
            end
        end
        drain();
        check_obs("latency_val", 0, 999, 0);
    endtask

    task automatic test_zero_freq();
        obs_q.delete();
        set_rate(0);
        step(0, 0, 0, 1, 1, 0);
        for (int n = 0; n < 8; n++) step(1, 1000, 0, 1, 0, 0);
        drain();
        for (int n = 0; n < 8; n++) check_obs("zero_freq", n, 999, 0);
    endtask

    task automatic test_quarter_turn();
        int ei[4] = '{999, 0, -1000, 0};
        int eq[4] = '{0, 999, 0, -1000};
        obs_q.delete();
        set_rate(0);
        step(0, 0, 0, 1, 1, 2**22);
        for (int n = 0; n < 8; n++) step(1, 1000, 0, 1, 0, 0);
        drain();
        for (int n = 0; n < 8; n++) check_obs("quarter_turn", n, ei[n % 4], eq[n % 4]);
    endtask

    task automatic test_saturation();
        obs_q.delete();
        set_rate(0);
        step(0, 0, 0, 1, 1, 2**21);
        step(1, -2048, -2048, 1, 0, 0);
        step(1, -2048, -2048, 1, 0, 0);
        drain();
        check_obs("saturate", 0, -2047, -2047);
        check_obs("saturate", 1, 0, -2048);
    endtask

    task automatic test_load_same_cycle();
        obs_q.delete();
        set_rate(0);
        step(0, 0, 0, 1, 1, 2**21);
        step(1, 700, -300, 1, 0, 0);
        step(1, 700, -300, 1, 0, 0);
        step(1, 1000, 0, 1, 1, 2**22);
        step(1, 1000, 0, 1, 0, 0);
        step(1, 1000, 0, 1, 0, 0);
        drain();
        check_obs("load_same", 2, 999, 0);
        check_obs("load_same", 3, 0, 999);
        check_obs("load_same", 4, -1000, 0);
    endtask

    task automatic test_back_to_back();
        localparam int N = 120;
        int si[N], sq[N];
        samp_t obs_a[$];
        int finit, idx, cyc;
        bit burst_low;
        finit = int'($urandom_range(0, 2**22)) - 2**21;
        set_rate(int'($urandom_range(0, 2**14)) - 2**13);
        for (int n = 0; n < N; n++) begin
            si[n] = int'($urandom_range(0, 4095)) - 2048;
            sq[n] = int'($urandom_range(0, 4095)) - 2048;
        end

        obs_q.delete();
        step(0, 0, 0, 1, 1, finit);
        for (int n = 0; n < N; n++) begin
            step(1, si[n], sq[n], 1, 0, 0);
            checks++;
            if (!last_acc) begin
                errors++;
                $display("FAIL throughput[%0d]: got accept 0 want 1", n);
            end
        end
        drain();
        obs_a = obs_q;

        obs_q.delete();
        step(0, 0, 0, 1, 1, finit);
        idx = 0; cyc = 0; burst_low = 1'b0;
        while (idx < N && cyc < 3000) begin
            if (cyc % 5 == 0) burst_low = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) != 0), si[idx], sq[idx], !burst_low, 0, 0);
            if (last_acc) idx++;
            cyc++;
        end
        checks++;
        if (idx != N) begin
            errors++;
            $display("FAIL bp_progress: got %0d accepted want %0d", idx, N);
        end
        drain();
        checks++;
        if (obs_q.size() != obs_a.size() || obs_a.size() != N) begin
            errors++;
            $display("FAIL bp_count: got %0d want %0d (ref run %0d)", obs_q.size(), N, obs_a.size());
        end else begin
            for (int n = 0; n < N; n++) begin
                checks++;
                if (obs_q[n].i !== obs_a[n].i || obs_q[n].q !== obs_a[n].q) begin
                    errors++;
                    $display("FAIL bp_vs_ref[%0d]: got (%0d,%0d) want (%0d,%0d)",
                             n, obs_q[n].i, obs_q[n].q, obs_a[n].i, obs_a[n].q);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_rate(0);
        step(0, 0, 0, 1, 1, 2**21);
        for (int n = 0; n < 3; n++) step(1, 500, 200, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1; bus0.in_valid = 1'b1; load0 = 1'b1; freq_init0 = 24'h200000;
        @(negedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush: got out_valid %b want 0", bus0.out_valid);
        end
        rst = 1'b0; bus0.in_valid = 1'b0; load0 = 1'b0;
        model_reset();
        for (int n = 0; n < 5; n++) begin
            step(0, 0, 0, 1, 0, 0);
            checks++;
            if (last_ov !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale[%0d]: got out_valid %b want 0", n, last_ov);
            end
        end
        obs_q.delete();
        step(1, 1000, 0, 1, 0, 0);
        step(1, 1000, 0, 1, 0, 0);
        drain();
        check_obs("post_rst", 0, 999, 0);
        check_obs("post_rst", 1, 999, 0);
    endtask

    task automatic test_ramp();
        int rates[2] = '{16, -16};
        longint fexp;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.in_i = '0; bus1.in_q = '0;
            load1 = 1'b1; freq_init1 = '0; freq_rate1 = rates[r][PB-1:0];
            @(negedge clk);
            load1 = 1'b0; bus1.in_valid = 1'b1;
            for (int n = 1; n <= 24; n++) begin
                @(negedge clk);
                #1;
                fexp = clampf(longint'(rates[r]) * (n / 4), 64);
                checks++;
                if (freq_word1 !== fexp[PB-1:0]) begin
                    errors++;
                    $display("FAIL ramp r=%0d n=%0d: got %0d want %0d", rates[r], n, freq_word1, fexp);
                end
            end
            bus1.in_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.in_valid = 1'b0; bus0.in_i = '0; bus0.in_q = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_i = '0; bus1.in_q = '0; bus1.out_ready = 1'b1;
        rate0 = 0;
        model_reset();
        test_reset();
        test_latency();
        test_zero_freq();
        test_quarter_turn();
        test_saturation();
        test_load_same_cycle();
        test_back_to_back();
        test_reset_midstream();
        test_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/doppler_emulator.md
DOPPLER_EMULATOR -- requirements
Module: doppler_emulator

Interface
REQ-001 SHALL have parameter InputLengthBits, default 12, I/Q sample width.
REQ-002 SHALL have parameter PhaseBits, default 24, phase-accumulator and frequency-word width.
REQ-003 SHALL have parameter LutAddrBits, default 8, sin/cos table address width (table depth 2^LutAddrBits).
REQ-004 SHALL have parameter RateInterval, default 1024, accepted samples between frequency-ramp steps.
REQ-005 SHALL have parameter FreqLimit, default 2^(PhaseBits-2), magnitude clamp on the frequency word.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_i, in_q  input  signed InputLengthBits  baseband sample.
REQ-009 in_valid  input  1  sample present; in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-010 freq_init  input  signed PhaseBits  starting frequency word (cycles/sample x 2^PhaseBits).
REQ-011 freq_rate  input  signed PhaseBits  increment added to frequency word every RateInterval accepted samples.
REQ-012 load  input  1  one-cycle pulse: load freq_init, clear phase and ramp counter.
REQ-013 out_i, out_q  output  signed InputLengthBits  frequency-shifted sample; out_valid  output  1; out_ready  input  1.
REQ-014 freq_word  output  signed PhaseBits  current frequency word (for bench/telemetry).

Function
REQ-015 Each accepted sample SHALL be rotated by the current phase: out = (in_i + j*in_q) * (cos + j*sin); positive freq_word SHALL shift spectrum up.
REQ-016 Phase index SHALL be phase[PhaseBits-1 -: LutAddrBits]; table values SHALL be round((2^(InputLengthBits-1)-1) * cos/sin(2*pi*k/2^LutAddrBits)).
REQ-017 out_i SHALL be (i*cos - q*sin) >>> (InputLengthBits-1), out_q = (i*sin + q*cos) >>> (InputLengthBits-1), arithmetic shift (floor), full-precision intermediate.
REQ-018 Results outside signed InputLengthBits range SHALL saturate to max/min; no wrap.
REQ-019 Sample n accepted SHALL use phase = sum of freq_word over samples 0..n-1 since last load/reset (first sample uses phase 0); phase SHALL wrap modulo 2^PhaseBits.
REQ-020 Ramp counter SHALL count accepted samples; on reaching RateInterval it SHALL reset to 0 and freq_word SHALL become clamp(freq_word + freq_rate, -FreqLimit, +FreqLimit).
REQ-021 Pipeline SHALL be 3 stages (table lookup, multiply, sum/saturate); latency from acceptance to out_valid SHALL be 3 cycles with no stall.
REQ-022 in_ready SHALL equal !(out_valid && !out_ready); when low all stages SHALL hold and out_i/out_q/out_valid SHALL stay stable.
REQ-023 With continuous in_valid and out_ready, throughput SHALL be one sample per cycle; no sample dropped or duplicated under any backpressure pattern.
REQ-024 load SHALL take effect in its cycle: freq_word<=freq_init, phase<=0, ramp counter<=0; a sample accepted in the same cycle SHALL use phase 0 and advance phase by freq_init.
REQ-025 load SHALL NOT flush samples already in the pipeline; they complete with their original phase.

Reset
REQ-026 On rst: out_i, out_q, out_valid, phase, ramp counter, freq_word SHALL be 0; pipeline valids cleared; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-027 rst mid-stream SHALL discard in-flight samples; rst SHALL override load and input acceptance in the same cycle.

Verification
REQ-028 load freq_init=0, freq_rate=0; stream (1000,0) -> every output (999,0) after 3-cycle latency.
REQ-029 load freq_init=2^22; stream (1000,0) -> outputs repeat (999,0),(0,999),(-1000,0),(0,-1000).
REQ-030 load freq_init=2^21; stream (-2048,-2048) -> second output (0,-2048) (saturated), first output (-2047,-2047).
REQ-031 RateInterval=4, freq_init=0, freq_rate=16, FreqLimit=64 -> freq_word 16 after 4 accepts, 32 after 8, holds 64 from 16 accepts onward; negative rate clamps at -64.
REQ-032 Random out_ready (50% low, bursts of 5): in_ready tracks REQ-022; output sequence identical to no-backpressure run.
REQ-033 rst asserted with 3 samples in flight -> out_valid 0 next cycle, no stale output after release; first post-reset sample uses phase 0 and freq_word 0.
